// File: rtl/conv2_seq_ctrl.sv
// Frame sequencer for the conv2 stage: gates pooled pixels into the line buffers,
// flags complete KxK windows, aligns them to the calc pipeline and signals frame end.
module conv2_seq_ctrl #(
    parameter int WIDTH    = 12,
    parameter int HEIGHT   = 12,
    parameter int K        = 5,
    parameter int CALC_LAT = 2
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           start,
    input  logic                           valid_in,
    output logic                           in_ready,
    output logic                           buf_valid_in,
    output logic                           win_valid,
    output logic                           out_valid,
    output logic [$clog2(HEIGHT-K+1)-1:0]  out_row,
    output logic [$clog2(WIDTH-K+1)-1:0]   out_col,
    output logic                           busy,
    output logic                           frame_done,
    output logic                           err_overrun
);
    localparam int OW   = WIDTH - K + 1;
    localparam int OH   = HEIGHT - K + 1;
    localparam int ORW  = $clog2(OH);
    localparam int OCW  = $clog2(OW);
    localparam int IRW  = $clog2(HEIGHT);
    localparam int ICW  = $clog2(WIDTH);
    localparam int NOUT = OH * OW;
    localparam int CNTW = $clog2(NOUT + 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t          r_state;
    logic            r_in_ready;
    logic            r_busy;
    logic            r_frame_done;
    logic            r_err_overrun;
    logic [IRW-1:0]  r_in_row;
    logic [ICW-1:0]  r_in_col;
    logic [CNTW-1:0] r_out_cnt;

    // Delay line aligning window flags/coordinates to the calc pipeline latency.
    logic [CALC_LAT-1:0] r_dl_v;
    logic [ORW-1:0]      r_dl_row [CALC_LAT];
    logic [OCW-1:0]      r_dl_col [CALC_LAT];

    logic            w_accept;
    logic            w_win_valid;
    logic            w_last_px;
    logic            w_pending;
    logic [ORW-1:0]  w_win_row;
    logic [OCW-1:0]  w_win_col;
    logic [CNTW-1:0] w_cnt_next;

    assign w_accept    = r_in_ready & valid_in;
    assign w_win_valid = w_accept && (r_in_row >= IRW'(K-1)) && (r_in_col >= ICW'(K-1));
    assign w_win_row   = ORW'(r_in_row - IRW'(K-1));
    assign w_win_col   = OCW'(r_in_col - ICW'(K-1));
    assign w_last_px   = (r_in_row == IRW'(HEIGHT-1)) && (r_in_col == ICW'(WIDTH-1));
    assign w_cnt_next  = r_out_cnt + CNTW'(r_dl_v[CALC_LAT-1]);

    // A window is still in flight if any stage except the one leaving this cycle holds one.
    always_comb begin
        w_pending = w_win_valid;
        for (int i = 0; i < CALC_LAT - 1; i++) begin
            w_pending = w_pending | r_dl_v[i];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_in_ready    <= 1'b0;
            r_busy        <= 1'b0;
            r_frame_done  <= 1'b0;
            r_err_overrun <= 1'b0;
            r_in_row      <= '0;
            r_in_col      <= '0;
            r_out_cnt     <= '0;
            r_dl_v        <= '0;
            for (int i = 0; i < CALC_LAT; i++) begin
                r_dl_row[i] <= '0;
                r_dl_col[i] <= '0;
            end
        end else begin
            r_dl_v[0]   <= w_win_valid;
            r_dl_row[0] <= w_win_valid ? w_win_row : '0;
            r_dl_col[0] <= w_win_valid ? w_win_col : '0;
            for (int i = 1; i < CALC_LAT; i++) begin
                r_dl_v[i]   <= r_dl_v[i-1];
                r_dl_row[i] <= r_dl_row[i-1];
                r_dl_col[i] <= r_dl_col[i-1];
            end

            r_out_cnt    <= w_cnt_next;
            r_frame_done <= 1'b0;
            if (valid_in && !r_in_ready) begin
                r_err_overrun <= 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state       <= S_RUN;
                        r_in_ready    <= 1'b1;
                        r_busy        <= 1'b1;
                        r_in_row      <= '0;
                        r_in_col      <= '0;
                        r_out_cnt     <= '0;
                        // Clear on arm, but a pixel arriving with start is still an overrun.
                        r_err_overrun <= valid_in;
                    end
                end
                S_RUN: begin
                    if (w_accept) begin
                        if (r_in_col == ICW'(WIDTH-1)) begin
                            r_in_col <= '0;
                            r_in_row <= r_in_row + IRW'(1);
                        end else begin
                            r_in_col <= r_in_col + ICW'(1);
                        end
                        if (w_last_px) begin
                            r_state    <= S_DRAIN;
                            r_in_ready <= 1'b0;
                        end
                    end
                end
                S_DRAIN: begin
                    if (!w_pending && (w_cnt_next == CNTW'(NOUT))) begin
                        r_state      <= S_DONE;
                        r_frame_done <= 1'b1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready     = r_in_ready;
    assign buf_valid_in = w_accept;
    assign win_valid    = w_win_valid;
    assign out_valid    = r_dl_v[CALC_LAT-1];
    assign out_row      = r_dl_row[CALC_LAT-1];
    assign out_col      = r_dl_col[CALC_LAT-1];
    assign busy         = r_busy;
    assign frame_done   = r_frame_done;
    assign err_overrun  = r_err_overrun;

endmodule

// File: tb/tb_conv2_seq_ctrl.sv
// Bench for conv2_seq_ctrl: three instances (CALC_LAT 2, 1, 4) share one stimulus;
// expected output timing/coordinates come from raster arithmetic on the driven pixels.
module tb_conv2_seq_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic valid_in = 1'b0;

    logic [2:0] rdy, bv, wv, ov, bsy, fd, err;
    logic [2:0] orow_a, ocol_a, orow_b, ocol_b, orow_c, ocol_c;

    int cyc = 0;
    int n_tests = 0;
    int n_fail = 0;
    int lat [3] = '{2, 1, 4};
    int c52 = -1;
    int c143 = -1;

    // Entries: {output cycle[31:0], row[2:0], col[2:0]}
    logic [37:0] exp_q[$];
    logic [37:0] obs_q[$];

    int ov_cnt [3];
    int first_ov [3];
    int last_ov [3];
    int fd_cnt [3];
    int fd_cyc [3];
    int wv_cnt [3];
    int bv_cnt [3];
    int busy_fall [3];
    logic [2:0] prev_busy = 3'b000;

    conv2_seq_ctrl #(.CALC_LAT(2)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start), .valid_in(valid_in),
        .in_ready(rdy[0]), .buf_valid_in(bv[0]), .win_valid(wv[0]), .out_valid(ov[0]),
        .out_row(orow_a), .out_col(ocol_a), .busy(bsy[0]), .frame_done(fd[0]),
        .err_overrun(err[0]));
    conv2_seq_ctrl #(.CALC_LAT(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start), .valid_in(valid_in),
        .in_ready(rdy[1]), .buf_valid_in(bv[1]), .win_valid(wv[1]), .out_valid(ov[1]),
        .out_row(orow_b), .out_col(ocol_b), .busy(bsy[1]), .frame_done(fd[1]),
        .err_overrun(err[1]));
    conv2_seq_ctrl #(.CALC_LAT(4)) dut_c (
        .clk(clk), .rst_n(rst_n), .start(start), .valid_in(valid_in),
        .in_ready(rdy[2]), .buf_valid_in(bv[2]), .win_valid(wv[2]), .out_valid(ov[2]),
        .out_row(orow_c), .out_col(ocol_c), .busy(bsy[2]), .frame_done(fd[2]),
        .err_overrun(err[2]));

    // Clock / cycle count
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL timeout: got no completion, expected finish before 500000");
        $fatal(1);
    end

    // Monitor: sampled on the falling edge
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (ov[k]) begin
                ov_cnt[k]++;
                if (first_ov[k] < 0) first_ov[k] = cyc;
                last_ov[k] = cyc;
            end
            if (fd[k]) begin
                fd_cnt[k]++;
                fd_cyc[k] = cyc;
            end
            if (wv[k]) wv_cnt[k]++;
            if (bv[k]) bv_cnt[k]++;
            if (prev_busy[k] && !bsy[k]) busy_fall[k] = cyc;
            prev_busy[k] = bsy[k];
        end
        if (ov[0]) obs_q.push_back({cyc[31:0], orow_a, ocol_a});
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_stats();
        obs_q.delete();
        for (int k = 0; k < 3; k++) begin
            ov_cnt[k] = 0; first_ov[k] = -1; last_ov[k] = -1; fd_cnt[k] = 0;
            fd_cyc[k] = -1; wv_cnt[k] = 0; bv_cnt[k] = 0; busy_fall[k] = -1;
        end
    endtask

    // Driver: start pulse, 144 pixels (mode 0 dense, 1 every other cycle, 2 random bubbles),
    // optional stray start / reset at a pixel index, optional extra pixels after the frame.
    task automatic drive_frame(input int mode, input int start_at, input int rst_at, input int extra);
        int c, r, cl;
        logic [37:0] tail;
        exp_q.delete();
        c52 = -1;
        c143 = -1;
        start = 1'b1;
        valid_in = 1'b0;
        step();
        start = 1'b0;
        for (int p = 0; p < 144; p++) begin
            if (mode == 1 && p > 0) begin
                valid_in = 1'b0; start = 1'b0; step();
            end
            if (mode == 2) begin
                repeat ($urandom_range(0, 2)) begin
                    valid_in = 1'b0; start = 1'b0; step();
                end
            end
            valid_in = 1'b1;
            start = (p == start_at);
            c = cyc;
            r = p / 12;
            cl = p % 12;
            if (p == 52) c52 = c;
            if (p == 143) c143 = c;
            if (r >= 4 && cl >= 4) begin
                exp_q.push_back({32'(c + 2), 3'(r - 4), 3'(cl - 4)});
            end
            if (p == rst_at) begin
                rst_n = 1'b0;
                step();
                rst_n = 1'b1;
                valid_in = 1'b0;
                start = 1'b0;
                // Only outputs already emitted before the reset edge survive.
                while (exp_q.size() > 0) begin
                    tail = exp_q[exp_q.size()-1];
                    if (int'(tail[37:6]) > c) void'(exp_q.pop_back());
                    else break;
                end
                return;
            end
            step();
        end
        valid_in = 1'b0;
        start = 1'b0;
        for (int e = 0; e < extra; e++) begin
            valid_in = 1'b1;
            step();
        end
        valid_in = 1'b0;
        repeat (14) step();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) step();
        n_tests++;
        if ({rdy[0], bv[0], wv[0], ov[0], orow_a, ocol_a, bsy[0], fd[0], err[0]} !== 12'h000) begin
            n_fail++;
            $display("FAIL reset_a: got %h expected 000",
                     {rdy[0], bv[0], wv[0], ov[0], orow_a, ocol_a, bsy[0], fd[0], err[0]});
        end
        n_tests++;
        if ({rdy[1], bv[1], wv[1], ov[1], orow_b, ocol_b, bsy[1], fd[1], err[1]} !== 12'h000) begin
            n_fail++;
            $display("FAIL reset_b: got %h expected 000",
                     {rdy[1], bv[1], wv[1], ov[1], orow_b, ocol_b, bsy[1], fd[1], err[1]});
        end
        n_tests++;
        if ({rdy[2], bv[2], wv[2], ov[2], orow_c, ocol_c, bsy[2], fd[2], err[2]} !== 12'h000) begin
            n_fail++;
            $display("FAIL reset_c: got %h expected 000",
                     {rdy[2], bv[2], wv[2], ov[2], orow_c, ocol_c, bsy[2], fd[2], err[2]});
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_back_to_back();
        int bad, n;
        clear_stats();
        drive_frame(0, -1, -1, 0);
        n_tests++;
        bad = -1;
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) if (bad < 0 && obs_q[i] !== exp_q[i]) bad = i;
        if (bad < 0 && obs_q.size() != exp_q.size()) bad = n;
        if (bad >= 0) begin
            n_fail++;
            $display("FAIL b2b_seq: at output %0d got %h (of %0d) expected %h (of %0d)",
                     bad, obs_q[bad], obs_q.size(), exp_q[bad], exp_q.size());
        end
        n_tests++;
        if (ov_cnt[0] !== 64) begin
            n_fail++; $display("FAIL b2b_count: got %0d expected 64", ov_cnt[0]);
        end
        n_tests++;
        if (first_ov[0] !== c52 + 2) begin
            n_fail++; $display("FAIL b2b_first: got cycle %0d expected %0d", first_ov[0], c52 + 2);
        end
        n_tests++;
        if (fd_cnt[0] !== 1 || fd_cyc[0] !== c143 + 3) begin
            n_fail++;
            $display("FAIL b2b_done: got %0d pulses at %0d expected 1 at %0d", fd_cnt[0], fd_cyc[0], c143 + 3);
        end
        n_tests++;
        if (busy_fall[0] !== c143 + 4) begin
            n_fail++; $display("FAIL b2b_busy: got fall at %0d expected %0d", busy_fall[0], c143 + 4);
        end
        n_tests++;
        if (wv_cnt[0] !== 64 || err[0] !== 1'b0) begin
            n_fail++; $display("FAIL b2b_win: got win %0d err %b expected 64 0", wv_cnt[0], err[0]);
        end
    endtask

    task automatic test_alternate();
        int bad, n;
        clear_stats();
        drive_frame(1, -1, -1, 0);
        n_tests++;
        bad = -1;
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) if (bad < 0 && obs_q[i] !== exp_q[i]) bad = i;
        if (bad < 0 && obs_q.size() != exp_q.size()) bad = n;
        if (bad >= 0) begin
            n_fail++;
            $display("FAIL alt_seq: at output %0d got %h (of %0d) expected %h (of %0d)",
                     bad, obs_q[bad], obs_q.size(), exp_q[bad], exp_q.size());
        end
        n_tests++;
        if (wv_cnt[0] !== 64 || bv_cnt[0] !== 144) begin
            n_fail++; $display("FAIL alt_counts: got win %0d buf %0d expected 64 144", wv_cnt[0], bv_cnt[0]);
        end
        n_tests++;
        if (err[0] !== 1'b0 || fd_cnt[0] !== 1) begin
            n_fail++; $display("FAIL alt_flags: got err %b done %0d expected 0 1", err[0], fd_cnt[0]);
        end
    endtask

    task automatic test_overrun();
        clear_stats();
        valid_in = 1'b1;
        repeat (2) step();
        valid_in = 1'b0;
        step();
        n_tests++;
        if (err[0] !== 1'b1 || bv_cnt[0] !== 0) begin
            n_fail++; $display("FAIL idle_overrun: got err %b buf %0d expected 1 0", err[0], bv_cnt[0]);
        end
        clear_stats();
        drive_frame(0, -1, -1, 3);
        n_tests++;
        if (err[0] !== 1'b1 || err[1] !== 1'b1 || err[2] !== 1'b1) begin
            n_fail++; $display("FAIL drain_overrun_sticky: got %b expected 111", err);
        end
        n_tests++;
        if (bv_cnt[0] !== 144 || ov_cnt[0] !== 64) begin
            n_fail++; $display("FAIL overrun_counts: got buf %0d out %0d expected 144 64", bv_cnt[0], ov_cnt[0]);
        end
    endtask

    task automatic test_start_midframe();
        int bad, n;
        clear_stats();
        drive_frame(0, 70, -1, 0);
        n_tests++;
        bad = -1;
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) if (bad < 0 && obs_q[i] !== exp_q[i]) bad = i;
        if (bad < 0 && obs_q.size() != exp_q.size()) bad = n;
        if (bad >= 0) begin
            n_fail++;
            $display("FAIL midstart_seq: at output %0d got %h (of %0d) expected %h (of %0d)",
                     bad, obs_q[bad], obs_q.size(), exp_q[bad], exp_q.size());
        end
        n_tests++;
        if (fd_cnt[0] !== 1 || fd_cyc[0] !== c143 + 3) begin
            n_fail++; $display("FAIL midstart_done: got %0d at %0d expected 1 at %0d", fd_cnt[0], fd_cyc[0], c143 + 3);
        end
        n_tests++;
        if (err[0] !== 1'b0) begin
            n_fail++; $display("FAIL midstart_err_cleared: got %b expected 0", err[0]);
        end
    endtask

    task automatic test_reset_midframe();
        int bad, n;
        clear_stats();
        drive_frame(0, -1, 100, 0);
        n_tests++;
        if ({rdy[0], bv[0], wv[0], ov[0], orow_a, ocol_a, bsy[0], fd[0], err[0]} !== 12'h000) begin
            n_fail++;
            $display("FAIL midreset_outputs: got %h expected 000",
                     {rdy[0], bv[0], wv[0], ov[0], orow_a, ocol_a, bsy[0], fd[0], err[0]});
        end
        n_tests++;
        bad = -1;
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) if (bad < 0 && obs_q[i] !== exp_q[i]) bad = i;
        if (bad < 0 && obs_q.size() != exp_q.size()) bad = n;
        if (bad >= 0) begin
            n_fail++;
            $display("FAIL midreset_pre_seq: at output %0d got %h (of %0d) expected %h (of %0d)",
                     bad, obs_q[bad], obs_q.size(), exp_q[bad], exp_q.size());
        end
        clear_stats();
        repeat (20) step();
        n_tests++;
        if (ov_cnt[0] + ov_cnt[1] + ov_cnt[2] !== 0 || fd_cnt[0] + fd_cnt[1] + fd_cnt[2] !== 0) begin
            n_fail++;
            $display("FAIL midreset_quiet: got out %0d done %0d expected 0 0",
                     ov_cnt[0] + ov_cnt[1] + ov_cnt[2], fd_cnt[0] + fd_cnt[1] + fd_cnt[2]);
        end
        clear_stats();
        drive_frame(0, -1, -1, 0);
        n_tests++;
        if (ov_cnt[0] !== 64 || fd_cnt[0] !== 1) begin
            n_fail++; $display("FAIL midreset_rerun: got out %0d done %0d expected 64 1", ov_cnt[0], fd_cnt[0]);
        end
    endtask

    task automatic test_latency();
        int bad, n;
        clear_stats();
        drive_frame(2, -1, -1, 0);
        n_tests++;
        bad = -1;
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) if (bad < 0 && obs_q[i] !== exp_q[i]) bad = i;
        if (bad < 0 && obs_q.size() != exp_q.size()) bad = n;
        if (bad >= 0) begin
            n_fail++;
            $display("FAIL bubble_seq: at output %0d got %h (of %0d) expected %h (of %0d)",
                     bad, obs_q[bad], obs_q.size(), exp_q[bad], exp_q.size());
        end
        for (int k = 0; k < 3; k++) begin
            n_tests++;
            if (first_ov[k] !== c52 + lat[k] || ov_cnt[k] !== 64) begin
                n_fail++;
                $display("FAIL lat%0d_first: got cycle %0d count %0d expected %0d 64",
                         lat[k], first_ov[k], ov_cnt[k], c52 + lat[k]);
            end
            n_tests++;
            if (fd_cyc[k] !== c143 + lat[k] + 1 || fd_cnt[k] !== 1) begin
                n_fail++;
                $display("FAIL lat%0d_done: got cycle %0d count %0d expected %0d 1",
                         lat[k], fd_cyc[k], fd_cnt[k], c143 + lat[k] + 1);
            end
        end
    endtask

    initial begin
        clear_stats();
        test_reset();
        test_back_to_back();
        test_alternate();
        test_overrun();
        test_start_midframe();
        test_reset_midframe();
        test_latency();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
